// File: rtl/charlieplex_scanner.sv
// -----------------------------------------------------------------------------
// charlieplex_scanner
//
// Shows 144-bit game-of-life frames on a 12x12 LED matrix charlieplexed over
// 13 tri-state pins. A shadow buffer takes frames through a valid/ready
// handshake. The active frame is replaced only at the end of a full scan,
// so a frame is never shown half old and half new.
//
// Each of the 12 anode phases has BLANK_CYCLES with every pin hi-Z, followed
// by DWELL_CYCLES with the anode driven high and the lit cathodes driven low.
//
// Ports:
//   clock        system clock, rising edge
//   aclr         synchronous active-high reset
//   frame_in     144 frame bits, bit k = LED k (anode k/12, column k%12)
//   frame_valid  frame_in is valid this cycle
//   frame_ready  shadow buffer empty, a frame can be accepted
//   pin_oe       per-pin output enable (0 = hi-Z)
//   pin_out      per-pin drive value, meaningful only where pin_oe = 1
//   phase        current anode phase, 0..11
//   frame_done   one-cycle pulse on the last drive cycle of phase 11
//   brightness   (CHARLIEPLEX_BRIGHTNESS_EN only) drive window is
//                ((brightness+1)*DWELL_CYCLES)/16 cycles of each dwell
//
// Optional feature macro: CHARLIEPLEX_BRIGHTNESS_EN
// -----------------------------------------------------------------------------
module charlieplex_scanner #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic         clock,
  input  logic         aclr,
  input  logic [143:0] frame_in,
  input  logic         frame_valid,
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
  input  logic [3:0]   brightness,
`endif
  output logic         frame_ready,
  output logic [12:0]  pin_oe,
  output logic [12:0]  pin_out,
  output logic [3:0]   phase,
  output logic         frame_done
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      phase_q, phase_d;
  logic            frame_done_q, frame_done_d;
  logic [12:0]     pin_oe_q, pin_oe_d;
  logic [12:0]     pin_out_q, pin_out_d;
  logic [143:0]    shadow_q, shadow_d;
  logic            shadow_full_q, shadow_full_d;
  logic [143:0]    active_q, active_d;

  logic            capture;
  logic            swap;
  logic            drive_en;
  logic [7:0]      row_base;
  logic [11:0]     row;
  logic [3:0]      cath;

`ifdef CHARLIEPLEX_BRIGHTNESS_EN
  localparam int PW = CW + 5;
  logic [3:0]      bright_q, bright_d;
  logic [PW-1:0]   drive_limit;
`endif

  // Scan timing: the counter restarts on every state change.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          phase_d = (phase_q == 4'd11) ? 4'd0 : phase_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Shadow and active buffers. A capture needs an empty shadow and a swap
  // needs a full one, so the two never act on the same edge.
  always_comb begin
    capture       = frame_valid && !shadow_full_q;
    swap          = frame_done_q && shadow_full_q;
    shadow_d      = capture ? frame_in : shadow_q;
    active_d      = swap ? shadow_q : active_q;
    shadow_full_d = shadow_full_q;
    if (capture) begin
      shadow_full_d = 1'b1;
    end else if (swap) begin
      shadow_full_d = 1'b0;
    end
  end

  // The outputs are computed from the next state, so the registered pins
  // line up with state_q/cnt_q. active_q changes only when going into BLANK,
  // so it is already correct whenever the next state is DRIVE.
  always_comb begin
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
    bright_d    = (state_q == ST_BLANK && state_d == ST_DRIVE) ? brightness : bright_q;
    drive_limit = ((PW'(bright_d) + PW'(1)) * PW'(DWELL_CYCLES)) >> 4;
    drive_en    = (state_d == ST_DRIVE) && (PW'(cnt_d) < drive_limit);
`else
    drive_en    = (state_d == ST_DRIVE);
`endif
    frame_done_d = (state_d == ST_DRIVE) && (phase_d == 4'd11) && (cnt_d == DWELL_LAST);
    row_base     = 8'(phase_d) * 8'd12;
    row          = active_q[row_base +: 12];
    pin_oe_d     = '0;
    pin_out_d    = '0;
    cath         = '0;
    if (drive_en) begin
      pin_oe_d[phase_d]  = 1'b1;
      pin_out_d[phase_d] = 1'b1;
      // Columns at or past the anode index skip over the anode pin.
      for (int c = 0; c < 12; c++) begin
        cath = (4'(c) < phase_d) ? 4'(c) : 4'(c) + 4'd1;
        if (row[4'(c)]) begin
          pin_oe_d[cath] = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the edge.
  always_ff @(posedge clock) begin
    // NOTE: shadow data is used only when shadow_full_q is set, so it is
    // not reset. The flags and the visible active frame are reset.
    shadow_q <= shadow_d;
    if (aclr) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      phase_q       <= '0;
      frame_done_q  <= 1'b0;
      pin_oe_q      <= '0;
      pin_out_q     <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
      bright_q      <= 4'hF;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      frame_done_q  <= frame_done_d;
      pin_oe_q      <= pin_oe_d;
      pin_out_q     <= pin_out_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
`ifdef CHARLIEPLEX_BRIGHTNESS_EN
      bright_q      <= bright_d;
`endif
    end
  end

  assign frame_ready = ~shadow_full_q;
  assign pin_oe      = pin_oe_q;
  assign pin_out     = pin_out_q;
  assign phase       = phase_q;
  assign frame_done  = frame_done_q;

endmodule
